// File: rtl/execute_stage_m.sv
// execute_stage_m: RV32IM execute stage. It contains the forwarding muxes, operand selects,
// ALU control and ALU, plus a sequential multiply/divide engine for M-extension ops.
// Base ops are combinational. M ops raise EX_stall_o until a result is ready.
// Optional macro EX_FAST_MUL_EN gives MUL* a single-cycle product. Divide stays iterative.
package execute_stage_pkg;
  // ALU op classes from decode: loads/stores add, branches subtract, R/I types decode funct3/funct7
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BRANCH = 2'b01, ALU_RTYPE = 2'b10, ALU_ITYPE = 2'b11} alu_op_e;
  // forwarding sources; the unused code 2'b11 falls back to the register file
  typedef enum logic [1:0] {FW_REG = 2'b00, FW_WB = 2'b01, FW_MEM = 2'b10} fw_sel_e;
endpackage

module execute_stage_m #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EX_valid_i,
  input  logic                  EX_flush_i,
  input  logic [DATA_WIDTH-1:0] EX_rd_data1_i,
  input  logic [DATA_WIDTH-1:0] EX_rd_data2_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] WB_alu_result_i,
  input  logic [DATA_WIDTH-1:0] EX_imm_i,
  input  logic [DATA_WIDTH-1:0] EX_pc_i,
  input  logic [DATA_WIDTH-1:0] EX_instruction_i,
  input  logic                  EX_ALUOpSrc1_i,
  input  logic                  EX_ALUOpSrc2_i,
  input  logic [1:0]            EX_ALUOp_i,
  input  logic [1:0]            EX_forwardA_i,
  input  logic [1:0]            EX_forwardB_i,
  output logic [DATA_WIDTH-1:0] EX_result_o,
  output logic                  EX_zeroFlag_o,
  output logic                  EX_result_valid_o,
  output logic                  EX_stall_o
);
  import execute_stage_pkg::*;

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND} alu_ctl_e;

  state_e          state_q, state_d;
  alu_ctl_e        alu_ctl;
  logic [W-1:0]    fwd_a, fwd_b, op1, op2, alu_res;
  logic [2:0]      funct3;
  logic            funct7b, m_op, launch;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [W-1:0]    mag_b_q, result_q;
  logic [2*W-1:0]  acc_q, acc_nxt, prod_fix;
  logic            unused_instr;

  assign funct3  = EX_instruction_i[14:12];
  assign funct7b = EX_instruction_i[30];
  assign m_op    = EX_valid_i && (EX_instruction_i[6:0] == 7'b0110011) && (EX_instruction_i[31:25] == 7'b0000001);
  assign unused_instr = ^{EX_instruction_i[24:15], EX_instruction_i[11:7]};

  // forwarding muxes, then PC/immediate operand selects
  always_comb begin
    fwd_a = EX_rd_data1_i;
    fwd_b = EX_rd_data2_i;
    case (EX_forwardA_i)
      FW_MEM:  fwd_a = MEM_alu_result_i;
      FW_WB:   fwd_a = WB_alu_result_i;
      default: ;
    endcase
    case (EX_forwardB_i)
      FW_MEM:  fwd_b = MEM_alu_result_i;
      FW_WB:   fwd_b = WB_alu_result_i;
      default: ;
    endcase
    op1 = EX_ALUOpSrc1_i ? EX_pc_i  : fwd_a;
    op2 = EX_ALUOpSrc2_i ? EX_imm_i : fwd_b;
  end

  // ALU control. instr[30] selects SUB only for R-type, and SRA for both R and I types.
  always_comb begin
    alu_ctl = A_ADD;
    case (EX_ALUOp_i)
      ALU_BRANCH: alu_ctl = A_SUB;
      ALU_RTYPE, ALU_ITYPE: begin
        case (funct3)
          3'b000:  alu_ctl = (EX_ALUOp_i == ALU_RTYPE && funct7b) ? A_SUB : A_ADD;
          3'b001:  alu_ctl = A_SLL;
          3'b010:  alu_ctl = A_SLT;
          3'b011:  alu_ctl = A_SLTU;
          3'b100:  alu_ctl = A_XOR;
          3'b101:  alu_ctl = funct7b ? A_SRA : A_SRL;
          3'b110:  alu_ctl = A_OR;
          default: alu_ctl = A_AND;
        endcase
      end
      default: ;
    endcase
  end

  // ALU
  always_comb begin
    alu_res = '0;
    case (alu_ctl)
      A_ADD:   alu_res = op1 + op2;
      A_SUB:   alu_res = op1 - op2;
      A_SLL:   alu_res = op1 << op2[SHW-1:0];
      A_SLT:   alu_res = {{(W-1){1'b0}}, $signed(op1) < $signed(op2)};
      A_SLTU:  alu_res = {{(W-1){1'b0}}, op1 < op2};
      A_XOR:   alu_res = op1 ^ op2;
      A_SRL:   alu_res = op1 >> op2[SHW-1:0];
      A_SRA:   alu_res = $unsigned($signed(op1) >>> op2[SHW-1:0]);
      A_OR:    alu_res = op1 | op2;
      A_AND:   alu_res = op1 & op2;
      default: ;
    endcase
  end

  // Launch decode. Signedness and magnitudes come from the forwarded rs1/rs2 values.
  // MUL is treated as signed because its low half does not depend on sign.
  logic         sgn_a_en, sgn_b_en, sa, sb, is_div, div_zero, div_ovf, fast;
  logic [W-1:0] mag_a, mag_b, fast_res;
  assign is_div   = funct3[2];
  assign sgn_a_en = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign sgn_b_en = is_div ? !funct3[0] : !funct3[1];
  assign sa       = sgn_a_en & fwd_a[W-1];
  assign sb       = sgn_b_en & fwd_b[W-1];
  assign mag_a    = sa ? -fwd_a : fwd_a;
  assign mag_b    = sb ? -fwd_b : fwd_b;
  assign div_zero = is_div && (fwd_b == '0);
  assign div_ovf  = is_div && !funct3[0] && (fwd_a == MIN_VAL) && (fwd_b == '1);

`ifdef EX_FAST_MUL_EN
  logic signed [2*W+1:0] fm_prod;
  logic                  unused_fm;
  assign fm_prod   = $signed({sa, fwd_a}) * $signed({sb, fwd_b});
  assign unused_fm = ^fm_prod[2*W+1:2*W];
  assign fast      = div_zero || div_ovf || !is_div;
`else
  assign fast      = div_zero || div_ovf;
`endif

  // Fast-path result that is registered at launch: divide by zero, signed overflow, fast multiply
  always_comb begin
    fast_res = '0;
    if (div_zero)     fast_res = funct3[1] ? fwd_a : '1;
    else if (div_ovf) fast_res = funct3[1] ? '0 : MIN_VAL;
`ifdef EX_FAST_MUL_EN
    else if (!is_div) fast_res = (funct3[1:0] == 2'b00) ? fm_prod[W-1:0] : fm_prod[2*W-1:W];
`endif
  end

  // One engine step: shift-add for multiply, restoring subtract for divide.
  // The sign-corrected result is built from the value computed in the last step.
  logic [W:0]   mul_sum, div_rsh, div_diff;
  logic [W-1:0] div_sel, iter_res;
  logic         neg;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_rsh  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_rsh - {1'b0, mag_b_q};
    if (op_q[2])
      acc_nxt = div_diff[W] ? {div_rsh[W-1:0], acc_q[W-2:0], 1'b0} : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    else
      acc_nxt = {mul_sum, acc_q[W-1:1]};
    neg      = (op_q[2] && op_q[1]) ? sa_q : (sa_q ^ sb_q);
    prod_fix = neg ? -acc_nxt : acc_nxt;
    div_sel  = op_q[1] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
    if (op_q[2])
      iter_res = neg ? -div_sel : div_sel;
    else
      iter_res = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and outputs. Flush and reset mask stall/valid combinationally.
  always_comb begin
    state_d           = state_q;
    launch            = 1'b0;
    EX_stall_o        = 1'b0;
    EX_result_valid_o = 1'b0;
    EX_result_o       = alu_res;
    EX_zeroFlag_o     = (alu_res == '0);
    case (state_q)
      S_IDLE: begin
        if (m_op) begin
          EX_stall_o = 1'b1;
          launch     = 1'b1;
          state_d    = fast ? S_DONE : S_BUSY;
        end else begin
          EX_result_valid_o = EX_valid_i;
        end
      end
      S_BUSY: begin
        EX_stall_o = 1'b1;
        if (cnt_q == CNT_WIDTH'(W-1)) state_d = S_DONE;
      end
      S_DONE: begin
        EX_result_o       = result_q;
        EX_zeroFlag_o     = (result_q == '0);
        EX_result_valid_o = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (EX_flush_i) begin
      state_d           = S_IDLE;
      launch            = 1'b0;
      EX_stall_o        = 1'b0;
      EX_result_valid_o = 1'b0;
    end
    if (rst) begin
      EX_stall_o        = 1'b0;
      EX_result_valid_o = 1'b0;
    end
  end

  // Engine registers. Operands are captured at launch because forwarding sources move while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (launch) begin
      cnt_q   <= '0;
      op_q    <= funct3;
      sa_q    <= sa;
      sb_q    <= sb;
      mag_b_q <= mag_b;
      acc_q   <= {{W{1'b0}}, mag_a};
      if (fast) result_q <= fast_res;
    end else if (state_q == S_BUSY && !EX_flush_i) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      acc_q <= acc_nxt;
      if (cnt_q == CNT_WIDTH'(W-1)) result_q <= iter_res;
    end
  end

endmodule

// File: tb/tb_execute_stage_m.sv
// tb_execute_stage_m: randomized and directed stimulus for execute_stage_m.
// It compares against a behavioural model that uses 64-bit arithmetic and latency rules.
// One negedge compare process checks stall, valid and result on every meaningful cycle.
module tb_execute_stage_m;
  import execute_stage_pkg::*;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid_i, EX_flush_i, EX_ALUOpSrc1_i, EX_ALUOpSrc2_i;
  logic [31:0] EX_rd_data1_i, EX_rd_data2_i, MEM_alu_result_i, WB_alu_result_i;
  logic [31:0] EX_imm_i, EX_pc_i, EX_instruction_i;
  logic [1:0]  EX_ALUOp_i, EX_forwardA_i, EX_forwardB_i;
  logic [31:0] EX_result_o;
  logic        EX_zeroFlag_o, EX_result_valid_o, EX_stall_o;

  int          n_checks = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_res_chk = 1'b0;
  logic [31:0] exp_res = '0;
  string       tag = "init";

  execute_stage_m #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .EX_valid_i(EX_valid_i), .EX_flush_i(EX_flush_i),
    .EX_rd_data1_i(EX_rd_data1_i), .EX_rd_data2_i(EX_rd_data2_i),
    .MEM_alu_result_i(MEM_alu_result_i), .WB_alu_result_i(WB_alu_result_i),
    .EX_imm_i(EX_imm_i), .EX_pc_i(EX_pc_i), .EX_instruction_i(EX_instruction_i),
    .EX_ALUOpSrc1_i(EX_ALUOpSrc1_i), .EX_ALUOpSrc2_i(EX_ALUOpSrc2_i), .EX_ALUOp_i(EX_ALUOp_i),
    .EX_forwardA_i(EX_forwardA_i), .EX_forwardB_i(EX_forwardB_i),
    .EX_result_o(EX_result_o), .EX_zeroFlag_o(EX_zeroFlag_o),
    .EX_result_valid_o(EX_result_valid_o), .EX_stall_o(EX_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  // Compare process: DUT outputs against the expectations the stimulus set for this cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check({tag, ":stall"}, 32'(EX_stall_o), 32'(exp_stall));
      check({tag, ":valid"}, 32'(EX_result_valid_o), 32'(exp_valid));
      if (exp_res_chk) begin
        check({tag, ":result"}, EX_result_o, exp_res);
        check({tag, ":zero"}, 32'(EX_zeroFlag_o), 32'(exp_res == 32'd0));
      end
    end
  end

  // Reference M-extension results using 64-bit arithmetic
  function automatic logic [31:0] mref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  function automatic int mlat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b & 32'd31);
    if (aop == 2'd0) return a + b;
    if (aop == 2'd1) return a - b;
    case (f3)
      3'd0: return (aop == 2'd2 && f7) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] fwd_pick(input logic [1:0] s, input logic [31:0] rd, input logic [31:0] mem,
                                           input logic [31:0] wb);
    if (s == 2'd2) return mem;
    if (s == 2'd1) return wb;
    return rd;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] m_instr(input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {7'b0000001, r[24:15], f3, r[11:7], 7'b0110011};
  endfunction

  function automatic logic [31:0] base_instr(input logic [1:0] aop, input logic [2:0] f3, input logic f7);
    logic [31:0] r;
    r = $urandom;
    case (aop)
      2'd0:    return {r[31:7], 7'b0000011};
      2'd1:    return {r[31:7], 7'b1100011};
      2'd2:    return {1'b0, f7, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
      default: return {r[31], f7, r[29:15], f3, r[11:7], 7'b0010011};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    EX_rd_data1_i = $urandom;  EX_rd_data2_i = $urandom;
    MEM_alu_result_i = $urandom; WB_alu_result_i = $urandom;
    EX_imm_i = $urandom; EX_pc_i = $urandom;
    EX_forwardA_i = 2'($urandom_range(0, 3)); EX_forwardB_i = 2'($urandom_range(0, 3));
    EX_ALUOpSrc1_i = 1'($urandom); EX_ALUOpSrc2_i = 1'($urandom);
  endtask

  // Route a and b through randomly chosen forwarding sources. PC/imm selects are randomized.
  task automatic drive_operands(input logic [31:0] a, input logic [31:0] b);
    int fa, fb;
    scramble();
    fa = $urandom_range(0, 3);
    fb = $urandom_range(0, 3);
    if ((fa == 1 || fa == 2) && fb == fa) fb = 0;
    EX_forwardA_i = 2'(fa);
    EX_forwardB_i = 2'(fb);
    case (fa)
      2: MEM_alu_result_i = a;
      1: WB_alu_result_i = a;
      default: EX_rd_data1_i = a;
    endcase
    case (fb)
      2: MEM_alu_result_i = b;
      1: WB_alu_result_i = b;
      default: EX_rd_data2_i = b;
    endcase
  endtask

  task automatic launch_m(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    step();
    rst = 1'b0;
    tag = name;
    EX_instruction_i = m_instr(f3);
    EX_valid_i = 1'b1;
    EX_flush_i = 1'b0;
    EX_ALUOp_i = 2'(ALU_RTYPE);
    drive_operands(a, b);
    exp_stall = 1'b1; exp_valid = 1'b0; exp_res_chk = 1'b0;
  endtask

  // Complete M op: stall for lat cycles, then a single valid cycle that carries want
  task automatic do_mop(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat);
    launch_m(name, f3, a, b);
    for (int k = 1; k < lat; k++) begin
      step();
      scramble();
      EX_valid_i = 1'($urandom);
    end
    step();
    scramble();
    EX_valid_i = 1'b1;
    exp_stall = 1'b0; exp_valid = 1'b1; exp_res = want; exp_res_chk = 1'b1;
  endtask

  task automatic do_base(input string name, input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                         input logic [1:0] fa, input logic [1:0] fb, input logic s1, input logic s2,
                         input logic vld, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] mem, input logic [31:0] wb, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] want);
    step();
    rst = 1'b0;
    tag = name;
    EX_instruction_i = base_instr(aop, f3, f7);
    EX_ALUOp_i = aop; EX_forwardA_i = fa; EX_forwardB_i = fb;
    EX_ALUOpSrc1_i = s1; EX_ALUOpSrc2_i = s2;
    EX_valid_i = vld; EX_flush_i = 1'b0;
    EX_rd_data1_i = rd1; EX_rd_data2_i = rd2;
    MEM_alu_result_i = mem; WB_alu_result_i = wb;
    EX_imm_i = imm; EX_pc_i = pc;
    exp_stall = 1'b0; exp_valid = vld; exp_res = want; exp_res_chk = 1'b1;
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      tag = name;
      EX_valid_i = 1'b0; EX_flush_i = 1'b0;
      exp_stall = 1'b0; exp_valid = 1'b0; exp_res_chk = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  aop, fa, fb;
    logic [2:0]  f3;
    logic        f7, s1, s2, vld;
    logic [31:0] rd1, rd2, mem, wb, imm, pc, a, b, opa, opb;

    rst = 1'b1; EX_valid_i = 1'b0; EX_flush_i = 1'b0;
    EX_rd_data1_i = '0; EX_rd_data2_i = '0; MEM_alu_result_i = '0; WB_alu_result_i = '0;
    EX_imm_i = '0; EX_pc_i = '0; EX_instruction_i = '0;
    EX_ALUOpSrc1_i = 1'b0; EX_ALUOpSrc2_i = 1'b0; EX_ALUOp_i = '0;
    EX_forwardA_i = '0; EX_forwardB_i = '0;

    // Pin the reference model with hand-computed values
    check("pin_div", mref(3'd4, 32'd100, 32'hFFFF_FFF9), 32'hFFFF_FFF2);
    check("pin_rem", mref(3'd6, 32'd100, 32'hFFFF_FFF9), 32'd2);
    check("pin_mulhu", mref(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulh", mref(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd0);
    check("pin_mulhsu", mref(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("pin_divovf", mref(3'd4, MINV, 32'hFFFF_FFFF), MINV);
    check("pin_sra", alu_ref(2'd2, 3'b101, 1'b1, 32'hF000_0000, 32'd4), 32'hFF00_0000);

    // While reset is held, a presented M op must neither stall nor signal valid
    step();
    chk_en = 1'b1; tag = "reset";
    exp_stall = 1'b0; exp_valid = 1'b0; exp_res_chk = 1'b0;
    EX_instruction_i = m_instr(3'd4); EX_valid_i = 1'b1;
    EX_rd_data1_i = 32'd100; EX_rd_data2_i = 32'd7;
    step();
    step();
    rst = 1'b0; EX_valid_i = 1'b0;
    idle_cycles("post_reset", 2);

    // Directed cases
    do_base("add_fwd_mem", 2'(ALU_RTYPE), 3'd0, 1'b0, 2'(FW_MEM), 2'(FW_REG), 1'b0, 1'b0, 1'b1,
            32'd77, 32'd3, 32'd5, 32'd99, 32'd1234, 32'h100, 32'd8);
    do_mop("div_100_m7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    do_mop("rem_100_m7", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    do_mop("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    do_mop("remu_9_by0", 3'd7, 32'd9, 32'd0, 32'd9, 1);
    do_mop("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, MINV, 1);
    do_mop("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 32'd0, 1);
    do_mop("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
    do_mop("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    do_mop("mul_low", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, MUL_LAT);

    // Flush at BUSY cycle 10: no valid pulse may follow
    launch_m("flush_div", 3'd4, 32'd100, 32'hFFFF_FFF9);
    for (int k = 1; k < 10; k++) step();
    step();
    EX_flush_i = 1'b1;
    exp_stall = 1'b0; exp_valid = 1'b0;
    do_base("add_after_flush", 2'(ALU_ADD), 3'd0, 1'b0, 2'(FW_REG), 2'(FW_REG), 1'b0, 1'b1, 1'b1,
            32'd40, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd42);
    idle_cycles("no_pulse_after_flush", 40);

    // Flush in the launch cycle: the op must not start
    launch_m("flush_launch", 3'd5, 32'd1000, 32'd3);
    EX_flush_i = 1'b1;
    exp_stall = 1'b0; exp_valid = 1'b0;
    idle_cycles("no_launch", 3);

    // Reset mid-divide discards the op, and the next ADD completes normally
    launch_m("rst_mid_div", 3'd4, 32'd1000, 32'd3);
    for (int k = 1; k < 5; k++) step();
    step();
    rst = 1'b1;
    tag = "rst_held";
    exp_stall = 1'b0; exp_valid = 1'b0;
    step();
    do_base("add_after_rst", 2'(ALU_RTYPE), 3'd0, 1'b0, 2'(FW_REG), 2'(FW_WB), 1'b0, 1'b0, 1'b1,
            32'd11, 32'd0, 32'd0, 32'd31, 32'd0, 32'd0, 32'd42);
    idle_cycles("idle_after_rst", 36);

    // Randomized mix of base and M ops
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        f3 = 3'($urandom_range(0, 7));
        a = rnd_val();
        b = rnd_val();
        do_mop("rand_m", f3, a, b, mref(f3, a, b), mlat(f3, a, b));
      end else begin
        aop = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7)); f7 = 1'($urandom);
        fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
        s1 = 1'($urandom); s2 = 1'($urandom); vld = ($urandom_range(0, 4) != 0);
        rd1 = rnd_val(); rd2 = rnd_val(); mem = rnd_val(); wb = rnd_val(); imm = rnd_val(); pc = $urandom;
        opa = s1 ? pc : fwd_pick(fa, rd1, mem, wb);
        opb = s2 ? imm : fwd_pick(fb, rd2, mem, wb);
        do_base("rand_base", aop, f3, f7, fa, fb, s1, s2, vld, rd1, rd2, mem, wb, imm, pc,
                alu_ref(aop, f3, f7, opa, opb));
      end
    end

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
